// File: rtl/sockit_spi_pkg.sv
// Shared definitions for the SPI transfer sequencer and the serializer:
// default sizes, IO mode encoding, FSM states, quc command layout and lane helper.
package sockit_spi_pkg;

    localparam int SDW_DEF = 32;
    localparam int SDL_DEF = 5;
    localparam int RLW_DEF = 16;

    localparam logic [1:0] IOM_3WIRE  = 2'd0;
    localparam logic [1:0] IOM_SINGLE = 2'd1;
    localparam logic [1:0] IOM_DUAL   = 2'd2;
    localparam logic [1:0] IOM_QUAD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [SDL_DEF-1:0] cnt;
        logic               cke;
        logic               sso;
        logic               die;
        logic               doe;
        logic [1:0]         iom;
        logic               lst;
    } quc_t;

    // Number of data lanes driven in the given IO mode (1, 2 or 4).
    function automatic logic [2:0] lane_cnt(input logic [1:0] iom);
        logic [2:0] n;
        case (iom)
            IOM_DUAL: n = 3'd2;
            IOM_QUAD: n = 3'd4;
            default:  n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sockit_spi_seq_if.sv
// Request, write-data, command-queue and output-queue signals of the sequencer.
// The slave view is the sequencer itself; the master view is its environment.
interface sockit_spi_seq_if #(
    parameter int SDW = 32,
    parameter int SDL = 5,
    parameter int RLW = 16
) ();

    logic             req_vld;
    logic             req_rdy;
    logic [RLW-1:0]   req_len;
    logic [1:0]       req_iom;
    logic             req_doe;
    logic             req_die;
    logic             req_sso;
    logic             req_lst;

    logic             wdt_vld;
    logic             wdt_rdy;
    logic [SDW-1:0]   wdt_dat;

    logic             quc_vld;
    logic             quc_rdy;
    logic [SDL-1:0]   quc_cnt;
    logic             quc_cke;
    logic             quc_sso;
    logic             quc_die;
    logic             quc_doe;
    logic [1:0]       quc_iom;
    logic             quc_lst;

    logic             quo_vld;
    logic             quo_rdy;
    logic [4*SDW-1:0] quo_dat;

    logic             busy;

    modport slave (
        input  req_vld, req_len, req_iom, req_doe, req_die, req_sso, req_lst,
        input  wdt_vld, wdt_dat, quc_rdy, quo_rdy,
        output req_rdy, wdt_rdy,
        output quc_vld, quc_cnt, quc_cke, quc_sso, quc_die, quc_doe, quc_iom, quc_lst,
        output quo_vld, quo_dat, busy
    );

    modport master (
        output req_vld, req_len, req_iom, req_doe, req_die, req_sso, req_lst,
        output wdt_vld, wdt_dat, quc_rdy, quo_rdy,
        input  req_rdy, wdt_rdy,
        input  quc_vld, quc_cnt, quc_cke, quc_sso, quc_die, quc_doe, quc_iom, quc_lst,
        input  quo_vld, quo_dat, busy
    );

endinterface

// File: rtl/sockit_spi_lmap.sv
// Combinational remap of one write word into the 4-lane MSB-aligned output layout.
// Lane j occupies lanes[j*SDW +: SDW]; serial cycle k is carried in bit SDW-1-k.
module sockit_spi_lmap
    import sockit_spi_pkg::*;
#(
    parameter int SDW = 32
) (
    input  logic [1:0]       iom,
    input  logic [SDW-1:0]   wrd,
    output logic [4*SDW-1:0] lanes
);

    // Spread consecutive word bits across the active lanes, MSB first.
    always_comb begin
        lanes = {(4*SDW){1'b0}};
        case (iom)
            IOM_DUAL: begin
                for (int k = 0; k < SDW/2; k++) begin
                    lanes[SDW + SDW-1-k] = wrd[SDW-1-2*k];
                    lanes[SDW-1-k]       = wrd[SDW-2-2*k];
                end
            end
            IOM_QUAD: begin
                for (int k = 0; k < SDW/4; k++) begin
                    for (int j = 0; j < 4; j++) begin
                        lanes[j*SDW + SDW-1-k] = wrd[SDW-1-4*k-(3-j)];
                    end
                end
            end
            default: begin
                lanes[SDW-1:0] = wrd;
            end
        endcase
    end

endmodule

// File: rtl/sockit_spi_seq.sv
// SPI transfer sequencer: splits one request into command-queue chunks of at most
// one data word and, for writes, issues the remapped word on the output queue
// together with its command.
module sockit_spi_seq
    import sockit_spi_pkg::*;
#(
    parameter int SDW = SDW_DEF,
    parameter int SDL = SDL_DEF,
    parameter int RLW = RLW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    sockit_spi_seq_if.slave bus
);

    seq_state_e       state_r, state_s;
    logic [RLW-1:0]   rem_r, rem_s;
    logic [RLW-1:0]   chunk_cur_s, cpw_s, chunk_s, chunk_m1_s;
    logic [1:0]       iom_r, iom_s;
    logic             doe_r, doe_s, die_r, die_s, sso_r, sso_s, lst_r, lst_s;
    quc_t             quc_r, quc_s;
    logic             quc_vld_r, quo_vld_r, req_rdy_r, wdt_rdy_r, busy_r;
    logic [4*SDW-1:0] quo_dat_r, lanes_s;
    logic             load_wrd_s, xfer_s;

    sockit_spi_lmap #(.SDW(SDW)) u_lmap (
        .iom   (iom_r),
        .wrd   (bus.wdt_dat),
        .lanes (lanes_s)
    );

    assign xfer_s = quc_vld_r & bus.quc_rdy & (~quo_vld_r | bus.quo_rdy);

    // Cycle count of the chunk currently offered (zero for a select-only update).
    always_comb begin
        if (quc_r.cke) begin
            chunk_cur_s = RLW'(quc_r.cnt) + RLW'(1'b1);
        end else begin
            chunk_cur_s = {RLW{1'b0}};
        end
    end

    // Next state, remaining length and latched request fields.
    always_comb begin
        state_s    = state_r;
        rem_s      = rem_r;
        iom_s      = iom_r;
        doe_s      = doe_r;
        die_s      = die_r;
        sso_s      = sso_r;
        lst_s      = lst_r;
        load_wrd_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_vld && req_rdy_r) begin
                    rem_s = bus.req_len;
                    iom_s = bus.req_iom;
                    doe_s = bus.req_doe & (bus.req_len != {RLW{1'b0}});
                    die_s = bus.req_die;
                    sso_s = bus.req_sso;
                    lst_s = bus.req_lst;
                    if (doe_s) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.wdt_vld && wdt_rdy_r) begin
                    load_wrd_s = 1'b1;
                    state_s    = ST_ISSUE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (xfer_s) begin
                    rem_s = rem_r - chunk_cur_s;
                    if (rem_s == {RLW{1'b0}}) begin
                        state_s = ST_IDLE;
                    end else if (doe_r) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Command for the chunk that the next ISSUE cycle will offer.
    always_comb begin
        cpw_s = RLW'(SDW) >> (lane_cnt(iom_s) >> 1);
        if (rem_s < cpw_s) begin
            chunk_s = rem_s;
        end else begin
            chunk_s = cpw_s;
        end
        chunk_m1_s = chunk_s - RLW'(1'b1);
        quc_s.cke  = (chunk_s != {RLW{1'b0}});
        if (quc_s.cke) begin
            quc_s.cnt = chunk_m1_s[SDL-1:0];
        end else begin
            quc_s.cnt = {SDL{1'b0}};
        end
        quc_s.sso = sso_s;
        quc_s.die = die_s;
        quc_s.doe = doe_s;
        quc_s.iom = iom_s;
        quc_s.lst = lst_s & (rem_s == chunk_s);
    end

    // State, counters and registered outputs; async reset drops any partial request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            rem_r     <= {RLW{1'b0}};
            iom_r     <= IOM_SINGLE;
            doe_r     <= 1'b0;
            die_r     <= 1'b0;
            sso_r     <= 1'b0;
            lst_r     <= 1'b0;
            quc_r     <= '{cnt: {SDL_DEF{1'b0}}, cke: 1'b0, sso: 1'b0, die: 1'b0,
                           doe: 1'b0, iom: IOM_SINGLE, lst: 1'b0};
            quc_vld_r <= 1'b0;
            quo_vld_r <= 1'b0;
            quo_dat_r <= {(4*SDW){1'b0}};
            req_rdy_r <= 1'b1;
            wdt_rdy_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            rem_r     <= rem_s;
            iom_r     <= iom_s;
            doe_r     <= doe_s;
            die_r     <= die_s;
            sso_r     <= sso_s;
            lst_r     <= lst_s;
            req_rdy_r <= (state_s == ST_IDLE);
            wdt_rdy_r <= (state_s == ST_FETCH);
            quc_vld_r <= (state_s == ST_ISSUE);
            quo_vld_r <= (state_s == ST_ISSUE) & doe_s;
            busy_r    <= (state_s != ST_IDLE);
            if (state_s == ST_ISSUE) begin
                quc_r <= quc_s;
            end else begin
                quc_r <= quc_r;
            end
            if (load_wrd_s) begin
                quo_dat_r <= lanes_s;
            end else begin
                quo_dat_r <= quo_dat_r;
            end
        end
    end

    assign bus.req_rdy = req_rdy_r;
    assign bus.wdt_rdy = wdt_rdy_r;
    assign bus.quc_vld = quc_vld_r;
    assign bus.quc_cnt = quc_r.cnt;
    assign bus.quc_cke = quc_r.cke;
    assign bus.quc_sso = quc_r.sso;
    assign bus.quc_die = quc_r.die;
    assign bus.quc_doe = quc_r.doe;
    assign bus.quc_iom = quc_r.iom;
    assign bus.quc_lst = quc_r.lst;
    assign bus.quo_vld = quo_vld_r;
    assign bus.quo_dat = quo_dat_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_sockit_spi_seq.sv
// Directed bench for the SPI transfer sequencer: write splitting, lane remap,
// reads, select-only updates, backpressure and mid-request reset.
module tb_sockit_spi_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   wdt_hs = 0;
    int   quc_hs = 0;

    sockit_spi_seq_if #(.SDW(32), .SDL(5), .RLW(16)) bus ();

    sockit_spi_seq #(.SDW(32), .SDL(5), .RLW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Count completed write-word and command handshakes.
    always @(posedge clk) begin
        if (bus.wdt_vld && bus.wdt_rdy) wdt_hs <= wdt_hs + 1;
        if (bus.quc_vld && bus.quc_rdy && (!bus.quo_vld || bus.quo_rdy)) quc_hs <= quc_hs + 1;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic take();
        @(negedge clk);
    endtask

    task automatic send_req(input logic [15:0] len, input logic [1:0] iom,
                            input logic doe, input logic die, input logic sso, input logic lst);
        bus.req_len = len; bus.req_iom = iom; bus.req_doe = doe;
        bus.req_die = die; bus.req_sso = sso; bus.req_lst = lst;
        bus.req_vld = 1'b1;
        @(negedge clk);
        bus.req_vld = 1'b0;
    endtask

    task automatic wait_quc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.quc_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [11:0] st;
        st = {bus.req_rdy, bus.quc_vld, bus.quo_vld, bus.wdt_rdy, bus.busy, bus.quc_iom,
              bus.quc_cke, bus.quc_lst, bus.quc_sso, bus.quc_die, bus.quc_doe};
        checks++; if (st !== 12'h820) begin errors++; $display("FAIL reset_flags got %h exp %h", st, 12'h820); end
        checks++; if (bus.quc_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.quc_cnt); end
        checks++; if (bus.quo_dat !== 128'd0) begin errors++; $display("FAIL reset_quo got %h exp 0", bus.quo_dat); end
    endtask

    task automatic test_single_write();
        bit ok; int w0; int q0;
        checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL sw_idle req_rdy got %b exp 1", bus.req_rdy); end
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'hA5A5_A5A5;
        w0 = wdt_hs; q0 = quc_hs;
        send_req(16'd40, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sw_c1_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_cke, bus.quc_lst, bus.quc_doe, bus.quc_sso, bus.quo_vld} !== {5'd31, 5'b10111})
            begin errors++; $display("FAIL sw_c1_cmd got cnt=%0d cke=%b lst=%b doe=%b sso=%b quo_vld=%b exp cnt=31 cke=1 lst=0 doe=1 sso=1 quo_vld=1",
                bus.quc_cnt, bus.quc_cke, bus.quc_lst, bus.quc_doe, bus.quc_sso, bus.quo_vld); end
        checks++; if (bus.quo_dat !== {96'd0, 32'hA5A5_A5A5}) begin errors++; $display("FAIL sw_c1_dat got %h exp A5A5A5A5 in lane0", bus.quo_dat); end
        bus.wdt_dat = 32'h1234_5678;
        take();
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sw_c2_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_cke, bus.quc_lst} !== {5'd7, 2'b11}) begin errors++;
            $display("FAIL sw_c2_cmd got cnt=%0d cke=%b lst=%b exp cnt=7 cke=1 lst=1", bus.quc_cnt, bus.quc_cke, bus.quc_lst); end
        checks++; if (bus.quo_dat !== {96'd0, 32'h1234_5678}) begin errors++; $display("FAIL sw_c2_dat got %h exp 12345678 in lane0", bus.quo_dat); end
        take(); take(); take();
        checks++; if ({bus.busy, bus.req_rdy, bus.wdt_rdy} !== 3'b010) begin errors++;
            $display("FAIL sw_end got busy=%b req_rdy=%b wdt_rdy=%b exp 0 1 0", bus.busy, bus.req_rdy, bus.wdt_rdy); end
        checks++; if (wdt_hs - w0 !== 2) begin errors++; $display("FAIL sw_words got %0d exp 2", wdt_hs - w0); end
        checks++; if (quc_hs - q0 !== 2) begin errors++; $display("FAIL sw_cmds got %0d exp 2", quc_hs - q0); end
        bus.wdt_vld = 1'b0;
    endtask

    task automatic test_quad_write();
        bit ok; int w0;
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'h1234_5678;
        w0 = wdt_hs;
        send_req(16'd8, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL qw_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_lst, bus.quc_iom} !== {5'd7, 1'b1, 2'd3}) begin errors++;
            $display("FAIL qw_cmd got cnt=%0d lst=%b iom=%0d exp cnt=7 lst=1 iom=3", bus.quc_cnt, bus.quc_lst, bus.quc_iom); end
        checks++; if (bus.quo_dat !== {32'h0100_0000, 32'h1E00_0000, 32'h6600_0000, 32'hAA00_0000}) begin errors++;
            $display("FAIL qw_lanes got %h exp 01000000_1E000000_66000000_AA000000", bus.quo_dat); end
        take(); take(); take();
        checks++; if (wdt_hs - w0 !== 1) begin errors++; $display("FAIL qw_words got %0d exp 1", wdt_hs - w0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL qw_busy got %b exp 0", bus.busy); end
        bus.wdt_vld = 1'b0;
    endtask

    task automatic test_dual_read();
        bit ok; int w0;
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'hFFFF_FFFF;
        w0 = wdt_hs;
        send_req(16'd20, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dr_c1_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_die, bus.quc_doe, bus.quc_lst, bus.quo_vld, bus.wdt_rdy, bus.quc_iom} !== {5'd15, 5'b10000, 2'd2})
            begin errors++; $display("FAIL dr_c1_cmd got cnt=%0d die=%b doe=%b lst=%b quo_vld=%b wdt_rdy=%b iom=%0d exp 15 1 0 0 0 0 2",
                bus.quc_cnt, bus.quc_die, bus.quc_doe, bus.quc_lst, bus.quo_vld, bus.wdt_rdy, bus.quc_iom); end
        take();
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dr_c2_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_die, bus.quc_lst, bus.quo_vld, bus.wdt_rdy} !== {5'd3, 4'b1100}) begin errors++;
            $display("FAIL dr_c2_cmd got cnt=%0d die=%b lst=%b quo_vld=%b wdt_rdy=%b exp 3 1 1 0 0",
                bus.quc_cnt, bus.quc_die, bus.quc_lst, bus.quo_vld, bus.wdt_rdy); end
        take(); take();
        checks++; if (wdt_hs - w0 !== 0) begin errors++; $display("FAIL dr_words got %0d exp 0", wdt_hs - w0); end
        bus.wdt_vld = 1'b0;
    endtask

    task automatic test_ss_only();
        bit ok; int w0;
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'h5555_5555;
        w0 = wdt_hs;
        send_req(16'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ss_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_cke, bus.quc_doe, bus.quc_sso, bus.quo_vld} !== {5'd0, 4'b0000}) begin errors++;
            $display("FAIL ss_cmd got cnt=%0d cke=%b doe=%b sso=%b quo_vld=%b exp 0 0 0 0 0",
                bus.quc_cnt, bus.quc_cke, bus.quc_doe, bus.quc_sso, bus.quo_vld); end
        take();
        checks++; if ({bus.req_rdy, bus.busy, bus.quc_vld} !== 3'b100) begin errors++;
            $display("FAIL ss_end got req_rdy=%b busy=%b quc_vld=%b exp 1 0 0", bus.req_rdy, bus.busy, bus.quc_vld); end
        checks++; if (wdt_hs - w0 !== 0) begin errors++; $display("FAIL ss_words got %0d exp 0", wdt_hs - w0); end
        bus.wdt_vld = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok; int w0; int q0;
        bus.quc_rdy = 1'b0;
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'hCAFE_F00D;
        w0 = wdt_hs; q0 = quc_hs;
        send_req(16'd40, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b exp 1", ok); end
        for (int i = 0; i < 5; i++) begin
            take();
            checks++; if ({bus.quc_vld, bus.quo_vld, bus.quc_cnt, bus.quo_dat[31:0]} !== {2'b11, 5'd31, 32'hCAFE_F00D} || quc_hs != q0)
                begin errors++; $display("FAIL bp_hold%0d got vld=%b/%b cnt=%0d dat=%h cmds=%0d exp 1/1 31 CAFEF00D 0",
                    i, bus.quc_vld, bus.quo_vld, bus.quc_cnt, bus.quo_dat[31:0], quc_hs - q0); end
        end
        checks++; if (wdt_hs - w0 !== 1) begin errors++; $display("FAIL bp_prefetch got %0d exp 1", wdt_hs - w0); end
        bus.quc_rdy = 1'b1; bus.quo_rdy = 1'b0;
        take(); take();
        checks++; if ({bus.quc_vld, bus.quc_cnt} !== {1'b1, 5'd31} || quc_hs != q0) begin errors++;
            $display("FAIL bp_quo_hold got vld=%b cnt=%0d cmds=%0d exp 1 31 0", bus.quc_vld, bus.quc_cnt, quc_hs - q0); end
        bus.quo_rdy = 1'b1; bus.wdt_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            take();
            checks++; if ({bus.quc_vld, bus.wdt_rdy} !== 2'b01) begin errors++;
                $display("FAIL bp_nodata%0d got quc_vld=%b wdt_rdy=%b exp 0 1", i, bus.quc_vld, bus.wdt_rdy); end
        end
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'h0BAD_BEEF;
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_c2_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_lst, bus.quo_dat[31:0]} !== {5'd7, 1'b0, 32'h0BAD_BEEF}) begin errors++;
            $display("FAIL bp_c2 got cnt=%0d lst=%b dat=%h exp 7 0 0BADBEEF", bus.quc_cnt, bus.quc_lst, bus.quo_dat[31:0]); end
        take();
        bus.wdt_vld = 1'b0;
        take();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [11:0] st;
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'h1111_1111;
        send_req(16'd64, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_quc(ok);
        take();
        wait_quc(ok);
        checks++; if ({ok, bus.quc_cnt, bus.quc_lst} !== {1'b1, 5'd31, 1'b1}) begin errors++;
            $display("FAIL rm_c2 got ok=%b cnt=%0d lst=%b exp 1 31 1", ok, bus.quc_cnt, bus.quc_lst); end
        rst = 1'b0;
        #1;
        st = {bus.req_rdy, bus.quc_vld, bus.quo_vld, bus.wdt_rdy, bus.busy, bus.quc_iom,
              bus.quc_cke, bus.quc_lst, bus.quc_sso, bus.quc_die, bus.quc_doe};
        checks++; if (st !== 12'h820) begin errors++; $display("FAIL rm_flags got %h exp %h", st, 12'h820); end
        checks++; if ({bus.quc_cnt, bus.quo_dat} !== 133'd0) begin errors++;
            $display("FAIL rm_data got cnt=%0d quo=%h exp 0 0", bus.quc_cnt, bus.quo_dat); end
        bus.wdt_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_after_reset();
        bit ok;
        checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL ar_idle got %b exp 1", bus.req_rdy); end
        bus.wdt_vld = 1'b1; bus.wdt_dat = 32'hAAAA_5555;
        send_req(16'd8, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_quc(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ar_timeout got %b exp 1", ok); end
        checks++; if ({bus.quc_cnt, bus.quc_lst, bus.quc_iom} !== {5'd7, 1'b1, 2'd2}) begin errors++;
            $display("FAIL ar_cmd got cnt=%0d lst=%b iom=%0d exp 7 1 2", bus.quc_cnt, bus.quc_lst, bus.quc_iom); end
        checks++; if (bus.quo_dat !== {64'd0, 32'hFF00_0000, 32'h00FF_0000}) begin errors++;
            $display("FAIL ar_lanes got %h exp 0_0_FF000000_00FF0000", bus.quo_dat); end
        take();
        bus.wdt_vld = 1'b0;
        take();
        checks++; if ({bus.busy, bus.req_rdy} !== 2'b01) begin errors++;
            $display("FAIL ar_end got busy=%b req_rdy=%b exp 0 1", bus.busy, bus.req_rdy); end
    endtask

    // Test sequence.
    initial begin
        rst = 1'b0;
        bus.req_vld = 1'b0; bus.req_len = 16'd0; bus.req_iom = 2'd0; bus.req_doe = 1'b0;
        bus.req_die = 1'b0; bus.req_sso = 1'b0; bus.req_lst = 1'b0;
        bus.wdt_vld = 1'b0; bus.wdt_dat = 32'd0;
        bus.quc_rdy = 1'b1; bus.quo_rdy = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_single_write();
        test_quad_write();
        test_dual_read();
        test_ss_only();
        test_backpressure();
        test_reset_mid();
        test_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
